// File: rtl/agu_reader.sv
// Read-side consumer of the AGU stream: issues one RAM read per accepted step,
// tracks the fixed read latency with a tag pipeline and re-times data through a credit-checked FIFO.
module agu_reader #(
  parameter int unsigned BWADDR = 21,
  parameter int unsigned BWDATA = 64,
  parameter int unsigned RDLAT  = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       step,
  output logic                       step_rdy,
  input  logic [BWADDR-1:0]          addr,
  input  logic [3:0]                 z,
  output logic                       rd_en,
  output logic [BWADDR-1:0]          rd_addr,
  input  logic [BWDATA-1:0]          rd_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [BWDATA-1:0]          o_data,
  output logic [3:0]                 o_z,
  output logic                       o_last,
  output logic [$clog2(DEPTH+1)-1:0] used
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RDLAT-1:0]  r_tv;
  logic [3:0]        r_tz [RDLAT];
  logic [BWDATA-1:0] r_md [DEPTH];
  logic [3:0]        r_mz [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_cnt;

  logic [CW-1:0]     w_used;
  logic              w_acc;
  logic              w_wr;
  logic              w_pop;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count every read already issued, so a result slot always exists on return.
  always_comb begin
    w_used = r_cnt;
    for (int unsigned i = 0; i < RDLAT; i++) begin
      w_used = w_used + CW'(r_tv[i]);
    end
  end

  assign step_rdy = rst_n & ~clr & (w_used < CW'(DEPTH));
  assign w_acc    = step & step_rdy;
  assign rd_en    = w_acc;
  assign rd_addr  = addr;

  assign w_wr     = r_tv[RDLAT-1];
  assign o_valid  = (r_cnt != '0);
  assign w_pop    = o_valid & o_ready;
  assign o_data   = r_md[r_rp];
  assign o_z      = r_mz[r_rp];
  assign o_last   = &o_z;
  assign used     = w_used;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tv  <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < RDLAT; i++) begin
        r_tz[i] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_md[i] <= '0;
        r_mz[i] <= '0;
      end
    end else if (clr) begin
      r_tv  <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_tv[0] <= w_acc;
      r_tz[0] <= z;
      for (int unsigned i = 1; i < RDLAT; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_tz[i] <= r_tz[i-1];
      end
      if (w_wr) begin
        r_md[r_wp] <= rd_data;
        r_mz[r_wp] <= r_tz[RDLAT-1];
        r_wp       <= f_next(r_wp);
      end
      if (w_pop) begin
        r_rp <= f_next(r_rp);
      end
      if (w_wr && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_wr && w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_agu_reader.sv
// Self-checking bench for agu_reader: fixed-latency RAM model plus a queue-based
// model of accepted-but-unconsumed results with their arrival cycles.
module tb_agu_reader;
  localparam int unsigned BWADDR = 21;
  localparam int unsigned BWDATA = 64;
  localparam int unsigned RDLAT  = 2;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              step = 1'b0;
  logic              o_ready = 1'b0;
  logic [BWADDR-1:0] addr = '0;
  logic [3:0]        z = '0;
  logic [BWDATA-1:0] rd_data;
  logic              step_rdy, rd_en, o_valid, o_last;
  logic [BWADDR-1:0] rd_addr;
  logic [BWDATA-1:0] o_data;
  logic [3:0]        o_z;
  logic [2:0]        used;

  int n_tests = 0;
  int n_fail  = 0;
  logic [42:0] salt = '0;

  agu_reader #(.BWADDR(BWADDR), .BWDATA(BWDATA), .RDLAT(RDLAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .step(step), .step_rdy(step_rdy),
    .addr(addr), .z(z), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_z(o_z),
    .o_last(o_last), .used(used)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ram_f(input logic [20:0] a);
    return {salt, a};
  endfunction

  // RAM: data for a read issued in cycle t is on rd_data during t+RDLAT, junk otherwise.
  logic [63:0]      ram_d [RDLAT];
  logic [RDLAT-1:0] ram_v = '0;
  logic [63:0]      junk = '0;
  always @(posedge clk) begin
    ram_v[0] <= rd_en;
    ram_d[0] <= ram_f(rd_addr);
    for (int i = 1; i < RDLAT; i++) begin
      ram_v[i] <= ram_v[i-1];
      ram_d[i] <= ram_d[i-1];
    end
    junk <= {$urandom, $urandom};
  end
  assign rd_data = ram_v[RDLAT-1] ? ram_d[RDLAT-1] : junk;

  // Reference: every accepted step waits in order until RDLAT+1 cycles after acceptance.
  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  zz;
    logic [31:0] arr;
  } ent_t;
  ent_t        m_q[$];
  int unsigned cyc = 0;
  int unsigned m_used = 0;
  logic        m_vis = 1'b0;
  logic [63:0] m_hd = '0;
  logic [3:0]  m_hz = '0;
  logic        exp_rdy;
  assign exp_rdy = (m_used < DEPTH) && !clr && rst_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      m_q.delete();
    end else begin
      if (m_vis && o_ready) void'(m_q.pop_front());
      if (step && exp_rdy) m_q.push_back('{d: ram_f(addr), zz: z, arr: cyc + RDLAT + 1});
    end
    if (rst_n) cyc++;
    m_used = m_q.size();
    m_vis  = (m_q.size() != 0) && (m_q[0].arr <= cyc);
    if (m_q.size() != 0) begin
      m_hd = m_q[0].d;
      m_hz = m_q[0].zz;
    end
  end

  // The FIFO can never be asked to hold more than DEPTH results.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_tests++;
      if (used > 3'(DEPTH)) begin
        n_fail++;
        $display("FAIL overfill used=%0d limit=%0d", used, DEPTH);
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; step = 1'b1; addr = 21'($urandom); z = 4'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (rd_en !== 1'b0 || step_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gate rd_en=%b step_rdy=%b expected 0/0", rd_en, step_rdy);
    end
    n_tests++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_z !== '0 || o_last !== 1'b0 || used !== '0) begin
      n_fail++;
      $display("FAIL reset_vals valid=%b data=%h z=%b last=%b used=%0d expected all 0",
               o_valid, o_data, o_z, o_last, used);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; step = 1'b0;
    @(negedge clk);
    n_tests++;
    if (step_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release step_rdy=%b expected 1", step_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single(input string nm);
    int first = -1;
    salt = '0; o_ready = 1'b1; step = 1'b1; addr = 21'h10; z = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_tests++;
        if (rd_en !== 1'b1 || rd_addr !== 21'h10) begin
          n_fail++;
          $display("FAIL %s_issue rd_en=%b rd_addr=%h expected 1/10", nm, rd_en, rd_addr);
        end
      end
      if (o_valid === 1'b1 && first < 0) begin
        first = k;
        n_tests++;
        if (o_data !== 64'h10 || o_z !== 4'b0001 || o_last !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_data data=%h z=%b last=%b expected 10/0001/0", nm, o_data, o_z, o_last);
        end
      end
      n_tests++;
      if (o_valid !== m_vis || used !== 3'(m_used)) begin
        n_fail++;
        $display("FAIL %s_state k=%0d valid=%b used=%0d expected %b/%0d", nm, k, o_valid, used, m_vis, m_used);
      end
      @(posedge clk); #1;
      step = 1'b0;
    end
    n_tests++;
    if (first != 3) begin
      n_fail++;
      $display("FAIL %s_latency first valid cycle=%0d expected 3", nm, first);
    end
  endtask

  task automatic test_stream;
    int first = -1;
    int outs = 0;
    salt = {11'($urandom), $urandom}; o_ready = 1'b1;
    for (int k = 0; k < 72; k++) begin
      step = (k < 64); addr = 21'(k); z = 4'($urandom);
      @(negedge clk);
      if (k < 64) begin
        n_tests++;
        if (step_rdy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== addr) begin
          n_fail++;
          $display("FAIL stream_issue k=%0d rdy=%b rd_en=%b rd_addr=%h expected 1/1/%h", k, step_rdy, rd_en, rd_addr, addr);
        end
      end
      n_tests++;
      if (o_valid !== m_vis || (m_vis && (o_data !== m_hd || o_z !== m_hz || o_last !== &m_hz))) begin
        n_fail++;
        $display("FAIL stream_out k=%0d valid=%b data=%h z=%b expected %b/%h/%b", k, o_valid, o_data, o_z, m_vis, m_hd, m_hz);
      end
      n_tests++;
      if (used !== 3'(m_used) || (k >= 3 && k < 64 && used !== 3'd3)) begin
        n_fail++;
        $display("FAIL stream_used k=%0d used=%0d expected %0d", k, used, m_used);
      end
      if (o_valid === 1'b1) begin
        if (first < 0) first = k;
        outs++;
      end
      @(posedge clk); #1;
    end
    step = 1'b0;
    n_tests++;
    if (first != 3 || outs != 64) begin
      n_fail++;
      $display("FAIL stream_count first=%0d outs=%0d expected 3/64", first, outs);
    end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    salt = {11'($urandom), $urandom}; o_ready = 1'b0; step = 1'b1;
    for (int k = 0; k < 8; k++) begin
      addr = 21'($urandom); z = 4'($urandom);
      @(negedge clk);
      if (step_rdy === 1'b1) acc++;
      n_tests++;
      if (o_valid !== m_vis || (m_vis && o_data !== m_hd) || used !== 3'(m_used) || step_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL bp_state k=%0d valid=%b data=%h used=%0d rdy=%b expected %b/%h/%0d/%b",
                 k, o_valid, o_data, used, step_rdy, m_vis, m_hd, m_used, exp_rdy);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (acc != 4) begin
      n_fail++;
      $display("FAIL bp_accepts accepted=%0d expected 4", acc);
    end
    o_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b1 || step_rdy !== 1'b0 || o_data !== m_hd) begin
      n_fail++;
      $display("FAIL bp_pop valid=%b rdy=%b data=%h expected 1/0/%h", o_valid, step_rdy, o_data, m_hd);
    end
    @(posedge clk); #1;
    o_ready = 1'b0; addr = 21'($urandom);
    @(negedge clk);
    n_tests++;
    if (step_rdy !== 1'b1 || rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_credit rdy=%b rd_en=%b expected 1/1", step_rdy, rd_en);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (step_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_refull rdy=%b expected 0", step_rdy);
    end
    @(posedge clk); #1;
    step = 1'b0; o_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (o_valid !== m_vis || (m_vis && (o_data !== m_hd || o_z !== m_hz)) || used !== 3'(m_used)) begin
        n_fail++;
        $display("FAIL bp_drain k=%0d valid=%b data=%h used=%0d expected %b/%h/%0d", k, o_valid, o_data, used, m_vis, m_hd, m_used);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flags;
    int outs = 0;
    salt = {11'($urandom), $urandom}; o_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step = (k < 8); addr = 21'($urandom);
      z = (k == 4) ? 4'hF : 4'($urandom_range(0, 14));
      @(negedge clk);
      n_tests++;
      if (o_valid !== m_vis || (m_vis && (o_data !== m_hd || o_z !== m_hz))) begin
        n_fail++;
        $display("FAIL flags_out k=%0d valid=%b data=%h z=%b expected %b/%h/%b", k, o_valid, o_data, o_z, m_vis, m_hd, m_hz);
      end
      if (o_valid === 1'b1) begin
        n_tests++;
        if (o_last !== (outs == 4) || (outs == 4 && o_z !== 4'hF)) begin
          n_fail++;
          $display("FAIL flags_last out=%0d last=%b z=%b expected last=%b", outs, o_last, o_z, (outs == 4));
        end
        outs++;
      end
      @(posedge clk); #1;
    end
    step = 1'b0;
    n_tests++;
    if (outs != 8) begin
      n_fail++;
      $display("FAIL flags_count outs=%0d expected 8", outs);
    end
  endtask

  task automatic test_flush;
    int outs = 0;
    salt = {11'($urandom), $urandom}; o_ready = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step = (k < 2) || (k == 6) || (k == 7) || (k == 8) || (k == 12);
      clr  = (k == 8);
      if (k >= 9) o_ready = 1'b1;
      addr = (k == 12) ? 21'h20 : 21'($urandom); z = 4'($urandom);
      @(negedge clk);
      if (k == 8) begin
        n_tests++;
        if (rd_en !== 1'b0 || step_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_clrcycle rd_en=%b rdy=%b expected 0/0", rd_en, step_rdy);
        end
      end
      if (k == 9) begin
        n_tests++;
        if (used !== 3'd0 || step_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL flush_after used=%0d rdy=%b expected 0/1", used, step_rdy);
        end
      end
      if (k >= 9 && k < 15) begin
        n_tests++;
        if (o_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_stale k=%0d valid=%b data=%h expected valid 0", k, o_valid, o_data);
        end
      end
      n_tests++;
      if (o_valid !== m_vis || used !== 3'(m_used) || step_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL flush_state k=%0d valid=%b used=%0d rdy=%b expected %b/%0d/%b", k, o_valid, used, step_rdy, m_vis, m_used, exp_rdy);
      end
      if (k >= 9 && o_valid === 1'b1) begin
        outs++;
        n_tests++;
        if (o_data !== ram_f(21'h20)) begin
          n_fail++;
          $display("FAIL flush_data data=%h expected %h", o_data, ram_f(21'h20));
        end
      end
      @(posedge clk); #1;
    end
    step = 1'b0; clr = 1'b0;
    n_tests++;
    if (outs != 1) begin
      n_fail++;
      $display("FAIL flush_count outs=%0d expected 1", outs);
    end
  endtask

  task automatic test_async_reset;
    salt = {11'($urandom), $urandom}; o_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step = (k < 3); addr = 21'($urandom); z = 4'($urandom);
      @(negedge clk);
      n_tests++;
      if (o_valid !== m_vis || (m_vis && o_data !== m_hd) || used !== 3'(m_used)) begin
        n_fail++;
        $display("FAIL arst_fill k=%0d valid=%b data=%h used=%0d expected %b/%h/%0d", k, o_valid, o_data, used, m_vis, m_hd, m_used);
      end
      @(posedge clk); #1;
    end
    step = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1 || used !== 3'd3) begin
      n_fail++;
      $display("FAIL arst_pre valid=%b used=%0d expected 1/3", o_valid, used);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_valid !== 1'b0 || used !== 3'd0 || step_rdy !== 1'b0 || o_data !== '0) begin
      n_fail++;
      $display("FAIL arst_now valid=%b used=%0d rdy=%b data=%h expected 0/0/0/0", o_valid, used, step_rdy, o_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_single("arst_single");
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_stream();
    test_backpressure();
    test_flags();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
